// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the rhythm-game judging path.
//   - Judge grade encoding (JDG_*), as seen on o_judge_t1/o_judge_t2.
//   - Per-track note FSM state type.
//   - Default timing/score constants. DEF_SCROLL_MS must match the scroll
//     controller's scroll period, otherwise the note windows drift.
// ----------------------------------------------------------------------------
package game_pkg;

    localparam logic [1:0] JDG_NONE    = 2'd0;
    localparam logic [1:0] JDG_PERFECT = 2'd1;
    localparam logic [1:0] JDG_GOOD    = 2'd2;
    localparam logic [1:0] JDG_MISS    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } trk_state_e;

    localparam int DEF_SCROLL_MS   = 300;
    localparam int DEF_PTS_PERFECT = 100;
    localparam int DEF_PTS_GOOD    = 50;
    localparam int COMBO_MAX       = 1023;

    // A grade that scores points and extends the combo.
    function automatic logic is_hit_grade(input logic [1:0] g);
        return (g == JDG_PERFECT) || (g == JDG_GOOD);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// One player button: 2-flop synchronizer, tick-based debouncer and a
// rising-edge pulse on the debounced level.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   i_tick   : 1 ms single-cycle strobe
//   i_btn    : raw asynchronous button, active-high
//   o_press  : one-cycle pulse when the debounced level rises
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts consecutive ticks on which the synchronized level differs from
    // the accepted level; any cycle of agreement restarts the count, so a
    // glitch shorter than DEBOUNCE_MS ticks is never accepted.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (i_tick) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= {sync_q[0], i_btn};
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign o_press = level_q & ~level_dly_q;

endmodule

// File: rtl/hit_judge.sv
// ----------------------------------------------------------------------------
// hit_judge
// Judging stage for the two-track rhythm game. Grades each note as
// PERFECT / GOOD / MISS, keeps score, combo and max combo, and drives the
// piezo tone pitch/enable.
//   clk, rst_n                : 50 MHz clock, asynchronous active-low reset
//   i_tick                    : 1 ms strobe
//   i_btn_t1/t2               : raw player buttons
//   i_hit_t1/t2               : high while a note occupies the judge cell
//   i_pitch_t1/t2             : pitch of the note in the judge cell
//   o_judge_t1/t2, _vld_*     : last grade per track and its update pulse
//   o_score, o_combo,
//   o_max_combo               : saturating score / combo statistics
//   o_tone_pitch, o_tone_en   : piezo drive
// ----------------------------------------------------------------------------
module hit_judge
    import game_pkg::*;
#(
    parameter int DEBOUNCE_MS = 10,
    parameter int SCROLL_MS   = DEF_SCROLL_MS,
    parameter int PERFECT_MS  = 100,
    parameter int TONE_MS     = 150,
    parameter int PTS_PERFECT = DEF_PTS_PERFECT,
    parameter int PTS_GOOD    = DEF_PTS_GOOD,
    parameter int SCORE_W     = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_tick,
    input  logic               i_btn_t1,
    input  logic               i_btn_t2,
    input  logic               i_hit_t1,
    input  logic               i_hit_t2,
    input  logic [31:0]        i_pitch_t1,
    input  logic [31:0]        i_pitch_t2,
    output logic [1:0]         o_judge_t1,
    output logic [1:0]         o_judge_t2,
    output logic               o_judge_vld_t1,
    output logic               o_judge_vld_t2,
    output logic [SCORE_W-1:0] o_score,
    output logic [9:0]         o_combo,
    output logic [9:0]         o_max_combo,
    output logic [31:0]        o_tone_pitch,
    output logic               o_tone_en
);

    localparam logic [8:0]  MS_LAST   = 9'(SCROLL_MS - 1);
    localparam logic [8:0]  MS_PERF   = 9'(PERFECT_MS);
    localparam int          SUM_W     = SCORE_W + 16;
    localparam int          TONE_W    = 16;
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_MS - 1);

    logic [1:0] btn_raw, hit_in;
    logic [1:0] grade_w [2];
    logic [1:0] judge_w [2];
    logic [1:0] grade_vld_w, judge_vld_w;
    logic [1:0] trk_hit, trk_miss;

    assign btn_raw = {i_btn_t2, i_btn_t1};
    assign hit_in  = {i_hit_t2, i_hit_t1};

    // ------------------------------------------------------------------
    // Per-track note FSM
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_trk
        trk_state_e state_q, state_d;
        logic [8:0] ms_q, ms_d;
        logic       hit_dly_q;
        logic       press, hit_rise, win_end;
        logic [1:0] grade, judge_q;
        logic       grade_vld, judge_vld_q;

        btn_debounce #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_tick  (i_tick),
            .i_btn   (btn_raw[gi]),
            .o_press (press)
        );

        assign hit_rise = hit_in[gi] & ~hit_dly_q;
        assign win_end  = i_tick && (ms_q == MS_LAST);

        // State register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= ST_IDLE;
                ms_q      <= '0;
                hit_dly_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                ms_q      <= ms_d;
                hit_dly_q <= hit_in[gi];
            end
        end

        // Next state. Priority: press > hit-fall > window rollover.
        always_comb begin
            state_d = state_q;
            ms_d    = ms_q;
            case (state_q)
                ST_IDLE: begin
                    ms_d = '0;
                    if (hit_rise) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (press) begin
                        state_d = ST_DONE;
                        // Elapsed time keeps running so DONE can detect the
                        // next adjacent note; a press on the last tick still
                        // closes the window.
                        if (i_tick) ms_d = win_end ? 9'd0 : ms_q + 1'b1;
                    end else if (!hit_in[gi]) begin
                        state_d = ST_IDLE;
                    end else if (win_end) begin
                        ms_d = '0;
                    end else if (i_tick) begin
                        ms_d = ms_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!hit_in[gi]) begin
                        state_d = ST_IDLE;
                    end else if (win_end) begin
                        state_d = ST_ARMED;
                        ms_d    = '0;
                    end else if (i_tick) begin
                        ms_d = ms_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Grade decided in the same cycle as the triggering event.
        always_comb begin
            grade     = JDG_NONE;
            grade_vld = 1'b0;
            if (state_q == ST_ARMED) begin
                if (press) begin
                    grade_vld = 1'b1;
                    grade     = (ms_q < MS_PERF) ? JDG_PERFECT : JDG_GOOD;
                end else if (!hit_in[gi] || win_end) begin
                    grade_vld = 1'b1;
                    grade     = JDG_MISS;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                judge_q     <= JDG_NONE;
                judge_vld_q <= 1'b0;
            end else begin
                judge_vld_q <= grade_vld;
                if (grade_vld) judge_q <= grade;
            end
        end

        assign grade_w[gi]     = grade;
        assign grade_vld_w[gi] = grade_vld;
        assign judge_w[gi]     = judge_q;
        assign judge_vld_w[gi] = judge_vld_q;
        assign trk_hit[gi]     = grade_vld && is_hit_grade(grade);
        assign trk_miss[gi]    = grade_vld && (grade == JDG_MISS);
    end

    assign o_judge_t1     = judge_w[0];
    assign o_judge_t2     = judge_w[1];
    assign o_judge_vld_t1 = judge_vld_w[0];
    assign o_judge_vld_t2 = judge_vld_w[1];

    // ------------------------------------------------------------------
    // Shared score / combo / tone
    // ------------------------------------------------------------------
    logic [SCORE_W-1:0] score_q, score_d;
    logic [9:0]         combo_q, combo_d, max_combo_q;
    logic [31:0]        tone_pitch_q, tone_pitch_d;
    logic               tone_en_q, tone_en_d;
    logic [TONE_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic [SUM_W-1:0]   pts_sum, score_sum;
    logic [10:0]        combo_sum;

    always_comb begin
        pts_sum = '0;
        for (int i = 0; i < 2; i++) begin
            if (trk_hit[i]) begin
                pts_sum = pts_sum + ((grade_w[i] == JDG_PERFECT) ?
                          SUM_W'(PTS_PERFECT) : SUM_W'(PTS_GOOD));
            end
        end
        score_sum = SUM_W'(score_q) + pts_sum;
        score_d   = (|score_sum[SUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}}
                                                  : score_sum[SCORE_W-1:0];

        combo_sum = {1'b0, combo_q} + 11'(trk_hit[0]) + 11'(trk_hit[1]);
        if (|trk_miss) begin
            combo_d = '0;                 // a miss wins even over a same-cycle hit
        end else if (combo_sum > 11'(COMBO_MAX)) begin
            combo_d = 10'(COMBO_MAX);
        end else begin
            combo_d = combo_sum[9:0];
        end

        tone_pitch_d = tone_pitch_q;
        tone_en_d    = tone_en_q;
        tone_cnt_d   = tone_cnt_q;
        if (|trk_hit) begin
            tone_pitch_d = trk_hit[0] ? i_pitch_t1 : i_pitch_t2;
            tone_en_d    = 1'b1;
            tone_cnt_d   = '0;
        end else if (tone_en_q && i_tick) begin
            if (tone_cnt_q == TONE_LAST) begin
                tone_en_d  = 1'b0;
                tone_cnt_d = '0;
            end else begin
                tone_cnt_d = tone_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q      <= '0;
            combo_q      <= '0;
            max_combo_q  <= '0;
            tone_pitch_q <= '0;
            tone_en_q    <= 1'b0;
            tone_cnt_q   <= '0;
        end else begin
            score_q      <= score_d;
            combo_q      <= combo_d;
            // Follows the registered combo, hence one cycle behind it.
            if (combo_q > max_combo_q) max_combo_q <= combo_q;
            tone_pitch_q <= tone_pitch_d;
            tone_en_q    <= tone_en_d;
            tone_cnt_q   <= tone_cnt_d;
        end
    end

    assign o_score      = score_q;
    assign o_combo      = combo_q;
    assign o_max_combo  = max_combo_q;
    assign o_tone_pitch = tone_pitch_q;
    assign o_tone_en    = tone_en_q;

endmodule

// File: tb/tb_hit_judge.sv
module tb_hit_judge;
    import game_pkg::*;

    localparam int SW       = 8;
    localparam int TICK_DIV = 4;
    localparam int SMAX     = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_tick = 1'b0;
    logic          i_btn_t1 = 1'b0, i_btn_t2 = 1'b0;
    logic          i_hit_t1 = 1'b0, i_hit_t2 = 1'b0;
    logic [31:0]   i_pitch_t1 = '0, i_pitch_t2 = '0;
    logic [1:0]    o_judge_t1, o_judge_t2;
    logic          o_judge_vld_t1, o_judge_vld_t2;
    logic [SW-1:0] o_score;
    logic [9:0]    o_combo, o_max_combo;
    logic [31:0]   o_tone_pitch;
    logic          o_tone_en;

    hit_judge #(
        .DEBOUNCE_MS (2),
        .SCORE_W     (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_tick         (i_tick),
        .i_btn_t1       (i_btn_t1),
        .i_btn_t2       (i_btn_t2),
        .i_hit_t1       (i_hit_t1),
        .i_hit_t2       (i_hit_t2),
        .i_pitch_t1     (i_pitch_t1),
        .i_pitch_t2     (i_pitch_t2),
        .o_judge_t1     (o_judge_t1),
        .o_judge_t2     (o_judge_t2),
        .o_judge_vld_t1 (o_judge_vld_t1),
        .o_judge_vld_t2 (o_judge_vld_t2),
        .o_score        (o_score),
        .o_combo        (o_combo),
        .o_max_combo    (o_max_combo),
        .o_tone_pitch   (o_tone_pitch),
        .o_tone_en      (o_tone_en)
    );

    always #10 clk = ~clk;

    // 1 ms strobe, one clock wide, every TICK_DIV clocks
    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 i_tick = 1'b1;
            @(posedge clk);
            #1 i_tick = 1'b0;
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  grade;
        logic [31:0] pitch;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   m_score = 0, m_combo = 0, m_max = 0;
    int   both_cnt = 0;

    function automatic int pts_of(input logic [1:0] g);
        return (g == JDG_PERFECT) ? 100 : (g == JDG_GOOD) ? 50 : 0;
    endfunction

    always @(negedge clk) begin : mon
        exp_t        r;
        logic        h1, h2, any_miss, any;
        int          nh, pts;
        logic [31:0] tp;
        h1 = 0; h2 = 0; any_miss = 0; any = 0; nh = 0; pts = 0; tp = '0;
        if (rst_n) begin
            if (o_judge_vld_t1) begin
                if (q1.size() == 0) chk("t1_spurious_vld", o_judge_vld_t1, 0);
                else begin
                    r = q1.pop_front();
                    any = 1;
                    chk("t1_grade", o_judge_t1, r.grade);
                    if (is_hit_grade(r.grade)) begin h1 = 1; nh++; pts += pts_of(r.grade); tp = r.pitch; end
                    else any_miss = 1;
                end
            end
            if (o_judge_vld_t2) begin
                if (q2.size() == 0) chk("t2_spurious_vld", o_judge_vld_t2, 0);
                else begin
                    r = q2.pop_front();
                    any = 1;
                    chk("t2_grade", o_judge_t2, r.grade);
                    if (is_hit_grade(r.grade)) begin
                        h2 = 1; nh++; pts += pts_of(r.grade);
                        if (!h1) tp = r.pitch;
                    end else any_miss = 1;
                end
            end
            if (o_judge_vld_t1 && o_judge_vld_t2) both_cnt++;
            if (any) begin
                m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
                m_combo = any_miss ? 0 : ((m_combo + nh > 1023) ? 1023 : m_combo + nh);
                if (m_combo > m_max) m_max = m_combo;
                chk("score", o_score, m_score);
                chk("combo", o_combo, m_combo);
                if (h1 || h2) begin
                    chk("tone_en_on_hit", o_tone_en, 1);
                    chk("tone_pitch", o_tone_pitch, tp);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!i_tick) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic press(input int trk);
        if (trk == 1) i_btn_t1 = 1'b1; else i_btn_t2 = 1'b1;
        wait_ticks(4);
        if (trk == 1) i_btn_t1 = 1'b0; else i_btn_t2 = 1'b0;
        wait_ticks(4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_btn_t1 = 0; i_btn_t2 = 0; i_hit_t1 = 0; i_hit_t2 = 0;
        q1.delete(); q2.delete();
        m_score = 0; m_combo = 0; m_max = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_exp(input int trk, input logic [1:0] g, input logic [31:0] p);
        exp_t e;
        e.grade = g;
        e.pitch = p;
        if (trk == 1) q1.push_back(e); else q2.push_back(e);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_judge_t1"}, o_judge_t1, 0);
        chk({tag, "_judge_t2"}, o_judge_t2, 0);
        chk({tag, "_vld"}, {o_judge_vld_t2, o_judge_vld_t1}, 0);
        chk({tag, "_score"}, o_score, 0);
        chk({tag, "_combo"}, o_combo, 0);
        chk({tag, "_max_combo"}, o_max_combo, 0);
        chk({tag, "_tone"}, {o_tone_en, o_tone_pitch}, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          trk;
        int          press_at;   // ticks after hit rise, -1 = no press
        int          hold;       // ticks the hit level stays high
        int          n_exp;
        logic [1:0]  e0;
        logic [1:0]  e1;
        logic [31:0] pitch;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    initial begin : main
        int n, k;
        vec[0] = '{1,  40, 250, 1, JDG_PERFECT, JDG_NONE,    32'h0000_0106};
        vec[1] = '{1, 180, 250, 1, JDG_GOOD,    JDG_NONE,    32'h0000_0126};
        vec[2] = '{2,  20, 150, 1, JDG_PERFECT, JDG_NONE,    32'h0000_0149};
        vec[3] = '{1,  60, 150, 1, JDG_PERFECT, JDG_NONE,    32'h0000_015D};
        vec[4] = '{2,  30, 150, 1, JDG_PERFECT, JDG_NONE,    32'h0000_0188};
        vec[5] = '{2,  -1, 299, 1, JDG_MISS,    JDG_NONE,    32'h0000_01B8};
        vec[6] = '{1,  -1, 590, 2, JDG_MISS,    JDG_MISS,    32'h0000_01EE};
        vec[7] = '{1, 350, 590, 2, JDG_MISS,    JDG_PERFECT, 32'h0000_020B};

        do_reset();
        chk_zero_outputs("reset");

        for (int i = 0; i < NV; i++) begin
            push_exp(vec[i].trk, vec[i].e0, vec[i].pitch);
            if (vec[i].n_exp > 1) push_exp(vec[i].trk, vec[i].e1, vec[i].pitch);
            if (vec[i].trk == 1) begin i_pitch_t1 = vec[i].pitch; i_hit_t1 = 1'b1; end
            else                 begin i_pitch_t2 = vec[i].pitch; i_hit_t2 = 1'b1; end
            if (vec[i].press_at >= 0) begin
                wait_ticks(vec[i].press_at);
                press(vec[i].trk);
                wait_ticks(vec[i].hold - vec[i].press_at - 8);
            end else begin
                wait_ticks(vec[i].hold);
            end
            i_hit_t1 = 1'b0;
            i_hit_t2 = 1'b0;
            wait_ticks(3);
            chk($sformatf("vec%0d_drained", i), q1.size() + q2.size(), 0);
            chk($sformatf("vec%0d_max_combo", i), o_max_combo, m_max);
        end
        chk("max_combo_kept_after_miss", o_max_combo, 5);

        // Tone length: enable stays up for exactly TONE_MS ticks after a hit
        i_pitch_t1 = 32'h0000_0CAF;
        i_hit_t1   = 1'b1;
        wait_ticks(20);
        push_exp(1, JDG_PERFECT, 32'h0000_0CAF);
        i_btn_t1 = 1'b1;
        k = 0;
        while (!o_tone_en && k < 200) begin @(negedge clk); k++; end
        chk("tone_rise", o_tone_en, 1);
        n = 0; k = 0;
        while (o_tone_en && k < 400 * TICK_DIV) begin
            if (i_tick) n++;
            @(negedge clk);
            k++;
        end
        chk("tone_len_ticks", n, 150);
        i_btn_t1 = 1'b0;
        i_hit_t1 = 1'b0;
        wait_ticks(6);
        chk("tone_seq_drained", q1.size(), 0);

        // Both tracks PERFECT in the same cycle
        do_reset();
        i_pitch_t1 = 32'h0000_1111;
        i_pitch_t2 = 32'h0000_2222;
        i_hit_t1 = 1'b1; i_hit_t2 = 1'b1;
        wait_ticks(30);
        push_exp(1, JDG_PERFECT, 32'h0000_1111);
        push_exp(2, JDG_PERFECT, 32'h0000_2222);
        i_btn_t1 = 1'b1; i_btn_t2 = 1'b1;
        wait_ticks(4);
        i_btn_t1 = 1'b0; i_btn_t2 = 1'b0;
        wait_ticks(4);
        chk("both_same_cycle", both_cnt, 1);
        chk("both_score", o_score, 200);
        chk("both_combo", o_combo, 2);
        chk("both_tone_pitch", o_tone_pitch, 32'h0000_1111);
        i_hit_t1 = 1'b0; i_hit_t2 = 1'b0;
        wait_ticks(3);
        chk("both_drained", q1.size() + q2.size(), 0);

        // One-tick glitches are rejected; the note then grades MISS
        i_hit_t2 = 1'b1;
        wait_ticks(30);
        for (int g = 0; g < 2; g++) begin
            i_btn_t2 = 1'b1;
            repeat (TICK_DIV) @(negedge clk);
            i_btn_t2 = 1'b0;
            wait_ticks(30);
        end
        push_exp(2, JDG_MISS, 32'h0);
        i_hit_t2 = 1'b0;
        wait_ticks(3);
        chk("glitch_drained", q2.size(), 0);
        chk("glitch_combo", o_combo, 0);
        chk("glitch_score", o_score, 200);

        // Press with no note pending is ignored
        press(1);
        wait_ticks(2);
        chk("idle_press_score", o_score, m_score);
        chk("idle_press_judge", o_judge_t1, JDG_PERFECT);

        // Reset in the middle of an armed window
        i_hit_t1 = 1'b1;
        wait_ticks(50);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        i_hit_t1 = 1'b0;
        m_score = 0; m_combo = 0; m_max = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(20);
        chk("midrst_no_miss", o_judge_t1, JDG_NONE);
        chk("midrst_drained", q1.size() + q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
